// File: rtl/ram_burst_reader.sv
// Burst reader: streams a contiguous block of RAM words out on a valid/ready port.
// The RAM port is shared with the CPU through an external request/grant arbiter.
module ram_burst_reader #(
    parameter int SIZE = 14,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] base_addr,
    input  logic [SIZE:0]   count,
    output logic            busy,
    output logic            done,
    output logic            bus_req,
    input  logic            bus_gnt,
    output logic            wrEn,
    output logic [SIZE-1:0] addr_toRAM,
    input  logic [DW-1:0]   data_fromRAM,
    output logic            o_valid,
    output logic [DW-1:0]   o_data,
    output logic            o_last,
    input  logic            i_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [SIZE-1:0] base_reg;
    logic [SIZE:0]   count_reg;
    logic [SIZE:0]   issued_reg;
    logic [SIZE-1:0] addr_reg;
    logic            inflight_reg;
    logic            inflight_last_reg;

    logic [DW-1:0]   fifo_data_reg [2];
    logic            fifo_last_reg [2];
    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      occ_reg;

    logic            accept;
    logic            pop;
    logic            capture;
    logic            issue;
    logic            issue_is_last;
    logic            credit_ok;
    logic [1:0]      occ_after_pop;
    logic [1:0]      credit_sum;
    logic [SIZE:0]   issued_inc;
    logic [SIZE-1:0] issue_addr;

    assign accept        = (state_reg == S_IDLE) && start;
    assign pop           = o_valid && i_ready;
    assign capture       = inflight_reg;
    assign issued_inc    = issued_reg + (SIZE+1)'(1);
    assign issue_is_last = (issued_inc == count_reg);
    assign issue_addr    = base_reg + issued_reg[SIZE-1:0];

    // A word leaving this cycle frees its slot, so back-to-back reads sustain one word per cycle.
    assign occ_after_pop = occ_reg - {1'b0, pop};
    assign credit_sum    = occ_after_pop + {1'b0, inflight_reg};
    assign credit_ok     = (credit_sum < 2'd2);

    assign issue = (state_reg == S_RUN) && bus_gnt && (issued_reg < count_reg) && credit_ok;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && issue_is_last) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_reg && (occ_after_pop == 2'd0)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign bus_req    = (state_reg == S_REQ) || (state_reg == S_RUN);
    assign wrEn       = 1'b0;
    assign addr_toRAM = issue ? issue_addr : addr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_reg          <= '0;
            count_reg         <= '0;
            issued_reg        <= '0;
            addr_reg          <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            if (accept) begin
                base_reg   <= base_addr;
                count_reg  <= count;
                issued_reg <= '0;
            end else if (issue) begin
                issued_reg <= issued_inc;
            end
            if (issue) begin
                addr_reg <= issue_addr;
            end
            // RAM data arrives one cycle after the address, independent of the grant.
            inflight_reg      <= issue;
            inflight_last_reg <= issue && issue_is_last;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    fifo_data_reg[gi] <= '0;
                    fifo_last_reg[gi] <= 1'b0;
                end else if (capture && (wr_ptr_reg == 1'(gi))) begin
                    fifo_data_reg[gi] <= data_fromRAM;
                    fifo_last_reg[gi] <= inflight_last_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (capture) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            occ_reg <= occ_after_pop + {1'b0, capture};
        end
    end

    assign o_valid = (occ_reg != 2'd0);
    assign o_data  = fifo_data_reg[rd_ptr_reg];
    assign o_last  = o_valid && fifo_last_reg[rd_ptr_reg];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: RAM model, stream monitor and hand-computed expectations.
module tb_ram_burst_reader;

    localparam int SIZE  = 14;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [SIZE-1:0] base_addr;
    logic [SIZE:0]   count;
    logic            busy;
    logic            done;
    logic            bus_req;
    logic            bus_gnt;
    logic            wrEn;
    logic [SIZE-1:0] addr_toRAM;
    logic [DW-1:0]   data_fromRAM;
    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic            i_ready;

    always #5 clk = ~clk;

    ram_burst_reader #(.SIZE(SIZE), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt), .wrEn(wrEn),
        .addr_toRAM(addr_toRAM), .data_fromRAM(data_fromRAM), .o_valid(o_valid),
        .o_data(o_data), .o_last(o_last), .i_ready(i_ready)
    );

    logic [DW-1:0] mem [DEPTH];

    initial begin
        data_fromRAM = '0;
        forever begin
            @(posedge clk);
            data_fromRAM <= mem[addr_toRAM];
        end
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int ncyc = 0;
    int start_cyc, first_valid_cyc, last_xfer_cyc, done_cyc, done_cnt, stall_err;
    bit req_seen, valid_seen, wren_seen, prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] rx_data [$];
    bit            rx_last [$];

    task automatic clear_mon();
        start_cyc = 0; first_valid_cyc = 0; last_xfer_cyc = 0; done_cyc = 0;
        done_cnt = 0; stall_err = 0;
        req_seen = 0; valid_seen = 0; wren_seen = 0; prev_stall = 0;
        prev_data = '0;
        rx_data.delete();
        rx_last.delete();
    endtask

    // Samples everything at the falling edge, half a cycle away from the active edge.
    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                prev_stall = 0;
            end else begin
                if (wrEn) wren_seen = 1;
                if (bus_req) req_seen = 1;
                if (start && !busy) start_cyc = ncyc;
                if (prev_stall && !(o_valid && o_data == prev_data)) stall_err++;
                prev_stall = o_valid && !i_ready;
                prev_data  = o_data;
                if (o_valid && !valid_seen) begin
                    first_valid_cyc = ncyc;
                    valid_seen = 1;
                end
                if (o_valid && i_ready) begin
                    rx_data.push_back(o_data);
                    rx_last.push_back(o_last);
                    last_xfer_cyc = ncyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = ncyc;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int c);
        base_addr = SIZE'(b);
        count     = (SIZE+1)'(c);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // ready_mode 1: ready follows 1,0,0,1; gnt_mode 1: grant low for the 3 cycles after the 2nd issue.
    task automatic run(input string tag, input int budget, input int ready_mode, input int gnt_mode);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            i_ready = (ready_mode == 1) ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
            bus_gnt = (gnt_mode == 1) ? !(n >= 3 && n <= 5) : 1'b1;
            tick();
            n++;
        end
        i_ready = 1'b1;
        bus_gnt = 1'b1;
        repeat (3) tick();
        check({tag, " done seen"}, 64'(done_cnt > 0), 64'd1);
        check({tag, " done count"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_stream(input string tag, input int b, input int c);
        int n;
        logic [63:0] last_mask;
        n = (rx_data.size() < c) ? rx_data.size() : c;
        check({tag, " words"}, 64'(rx_data.size()), 64'(c));
        last_mask = '0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s word%0d", tag, i), 64'(rx_data[i]), 64'(mem[(b + i) % DEPTH]));
            if (rx_last[i]) last_mask[i] = 1'b1;
        end
        check({tag, " last mask"}, last_mask, 64'd1 << (c - 1));
        check({tag, " stall hold"}, 64'(stall_err), 64'd0);
        check({tag, " wrEn"}, 64'(wren_seen), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " bus_req"}, 64'(bus_req), 64'd0);
        check({tag, " wrEn"}, 64'(wrEn), 64'd0);
        check({tag, " addr"}, 64'(addr_toRAM), 64'd0);
        check({tag, " o_valid"}, 64'(o_valid), 64'd0);
        check({tag, " o_data"}, 64'(o_data), 64'd0);
        check({tag, " o_last"}, 64'(o_last), 64'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'd3;
        mem[100]   = 32'd6;
        mem[101]   = 32'd0;
        mem[16382] = 32'hAAAA_0001;
        mem[16383] = 32'hBBBB_0002;
        mem[0]     = 32'hCCCC_0003;
        mem[1]     = 32'hDDDD_0004;

        rst = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        bus_gnt = 1'b1; i_ready = 1'b1;
        repeat (2) tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        repeat (2) tick();

        // Basic two-word burst with latency checks.
        clear_mon();
        do_start(100, 2);
        run("b2", 40, 0, 0);
        check_stream("b2", 100, 2);
        if (rx_data.size() == 2) begin
            check("b2 first=6", 64'(rx_data[0]), 64'd6);
            check("b2 second=0", 64'(rx_data[1]), 64'd0);
        end
        check("b2 first valid latency", 64'(first_valid_cyc - start_cyc), 64'd4);
        check("b2 done after last", 64'(done_cyc - last_xfer_cyc), 64'd1);
        $display("burst base=100 count=2 words=%0d", rx_data.size());

        // Zero-length command goes straight to the done pulse.
        clear_mon();
        do_start(50, 0);
        run("c0", 10, 0, 0);
        check("c0 done latency", 64'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 64'd1);
        check("c0 bus_req", 64'(req_seen), 64'd0);
        check("c0 o_valid", 64'(valid_seen), 64'd0);
        $display("burst base=50 count=0 done_cnt=%0d", done_cnt);

        // Address wrap around the top of memory.
        clear_mon();
        do_start(DEPTH - 2, 4);
        run("wrap", 40, 0, 0);
        check_stream("wrap", DEPTH - 2, 4);
        if (rx_data.size() == 4) begin
            check("wrap A", 64'(rx_data[0]), 64'hAAAA_0001);
            check("wrap D", 64'(rx_data[3]), 64'hDDDD_0004);
        end
        $display("burst base=%0d count=4 words=%0d", DEPTH - 2, rx_data.size());

        // Downstream backpressure pattern.
        clear_mon();
        do_start(200, 8);
        run("stall", 100, 1, 0);
        check_stream("stall", 200, 8);
        $display("burst base=200 count=8 stalled words=%0d", rx_data.size());

        // Grant withdrawn mid-burst.
        clear_mon();
        do_start(300, 6);
        run("gnt", 60, 0, 1);
        check_stream("gnt", 300, 6);
        $display("burst base=300 count=6 gnt-gap words=%0d", rx_data.size());

        // Reset after three words of a ten-word burst, then a fresh burst.
        clear_mon();
        do_start(400, 10);
        n = 0;
        while (rx_data.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        check("rst mid words", 64'(rx_data.size()), 64'd3);
        rst = 1'b0;
        #1;
        check_idle_outputs("rst mid");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        clear_mon();
        do_start(500, 2);
        run("post", 40, 0, 0);
        check_stream("post", 500, 2);
        $display("burst base=500 count=2 after reset words=%0d", rx_data.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
